// File: rtl/hazard_ctrl_unit_if.sv
// rtl/hazard_ctrl_unit_if.sv - pipeline status / sequencing control bundle for hazard_ctrl_unit
//
// Groups everything the hazard controller exchanges with the pipeline.
//   master : pipeline side, drives stage status, receives freeze/flush controls
//   slave  : hazard_ctrl_unit, observes stage status, drives controls and counters
// Status (master -> slave):
//   id_valid, id_src1, id_src1_used, id_src2, id_two_src,
//   exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
//   mem_access, mem_ready, branch_taken
// Controls (slave -> master):
//   freeze_if, freeze_id, flush_if, flush_id, freeze_all,
//   mem_timeout, stall_count[CNT_W], flush_count[CNT_W]
interface hazard_ctrl_unit_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_src1;
    logic             id_src1_used;
    logic [3:0]       id_src2;
    logic             id_two_src;
    logic [3:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [3:0]       mem_dest;
    logic             mem_wb_en;
    logic             mem_access;
    logic             mem_ready;
    logic             branch_taken;

    logic             freeze_if;
    logic             freeze_id;
    logic             flush_if;
    logic             flush_id;
    logic             freeze_all;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_src1, id_src1_used, id_src2, id_two_src,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
               mem_access, mem_ready, branch_taken,
        input  freeze_if, freeze_id, flush_if, flush_id, freeze_all,
               mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_src1, id_src1_used, id_src2, id_two_src,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
               mem_access, mem_ready, branch_taken,
        output freeze_if, freeze_id, flush_if, flush_id, freeze_all,
               mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - IF/ID and ID/EX sequencing: RAW bubbles, branch flush, memory-wait freeze with watchdog
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   hc  : hazard_ctrl_unit_if.slave (stage status in, freeze/flush controls and counters out)
// Parameters:
//   CNT_W        : width of stall_count / flush_count (saturating)
//   MAX_MEM_WAIT : consecutive memory-wait cycles that trip the watchdog (1..255)
// Build option:
//   HAZARD_FORWARDING_EN : when defined, only load-use matches against EX stall;
//                          otherwise any EX or MEM writeback match stalls.
// Control outputs are combinational from state and inputs; state, wait count,
// sticky timeout and counters are registered.
module hazard_ctrl_unit #(
    parameter int CNT_W        = 16,
    parameter int MAX_MEM_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    hazard_ctrl_unit_if.slave   hc
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    localparam logic [7:0] MAX_WAIT = 8'(MAX_MEM_WAIT);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic match_src1;
    logic match_src2;
    logic hazard;

`ifdef HAZARD_FORWARDING_EN
    // Forwarding covers ALU results from EX and everything in MEM; only a load
    // in EX cannot supply its data in time.
    assign match_src1 = hc.exe_wb_en & hc.exe_mem_read & (hc.id_src1 == hc.exe_dest);
    assign match_src2 = hc.exe_wb_en & hc.exe_mem_read & (hc.id_src2 == hc.exe_dest);

    logic unused_mem_stage;
    assign unused_mem_stage = hc.mem_wb_en ^ (^hc.mem_dest);
`else
    assign match_src1 = (hc.exe_wb_en & (hc.id_src1 == hc.exe_dest)) |
                        (hc.mem_wb_en & (hc.id_src1 == hc.mem_dest));
    assign match_src2 = (hc.exe_wb_en & (hc.id_src2 == hc.exe_dest)) |
                        (hc.mem_wb_en & (hc.id_src2 == hc.mem_dest));

    logic unused_load_flag;
    assign unused_load_flag = hc.exe_mem_read;
`endif

    assign hazard = hc.id_valid & ((hc.id_src1_used & match_src1) |
                                   (hc.id_two_src & match_src2));

    logic freeze_if, freeze_id, flush_if, flush_id, freeze_all;
    logic pipe_ctrl;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        freeze_if   = 1'b0;
        freeze_id   = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        freeze_all  = 1'b0;
        // Set when branch/hazard arbitration applies this cycle.
        pipe_ctrl   = 1'b0;

        case (state_q)
            RUN: begin
                if (hc.mem_access & ~hc.mem_ready) begin
                    freeze_if  = 1'b1;
                    freeze_id  = 1'b1;
                    freeze_all = 1'b1;
                    wait_cnt_d = 8'd1;
                    // The entry cycle already counts as one wait cycle.
                    if (MAX_WAIT == 8'd1) begin
                        timeout_d = 1'b1;
                        state_d   = HALT;
                    end else begin
                        state_d   = MEM_WAIT;
                    end
                end else begin
                    pipe_ctrl = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!hc.mem_ready) begin
                    freeze_if  = 1'b1;
                    freeze_id  = 1'b1;
                    freeze_all = 1'b1;
                    if ((wait_cnt_q + 8'd1) == MAX_WAIT) begin
                        timeout_d = 1'b1;
                        state_d   = HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    // Release cycle: a branch held during the wait is serviced now.
                    pipe_ctrl  = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end
            end
            default: begin
                freeze_if  = 1'b1;
                freeze_id  = 1'b1;
                freeze_all = 1'b1;
                state_d    = HALT;
            end
        endcase

        if (pipe_ctrl) begin
            if (hc.branch_taken) begin
                // The ID instruction is on the wrong path, so its hazard is moot.
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (hazard) begin
                freeze_if = 1'b1;
                freeze_id = 1'b1;
                flush_id  = 1'b1;
            end
        end

        if (state_q != HALT) begin
            if (freeze_id && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_if && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hc.freeze_if   = freeze_if;
    assign hc.freeze_id   = freeze_id;
    assign hc.flush_if    = flush_if;
    assign hc.flush_id    = flush_id;
    assign hc.freeze_all  = freeze_all;
    assign hc.mem_timeout = timeout_q;
    assign hc.stall_count = stall_cnt_q;
    assign hc.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit with a behavioural reference model
module tb_hazard_ctrl_unit;

    localparam int CNT_W   = 4;
    localparam int MAXW    = 15;
    localparam int SAT     = (1 << CNT_W) - 1;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;

    hazard_ctrl_unit_if #(.CNT_W(CNT_W)) hc ();

    hazard_ctrl_unit #(
        .CNT_W        (CNT_W),
        .MAX_MEM_WAIT (MAXW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hc  (hc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit m_halted;
    bit m_waiting;
    bit m_timeout;
    int m_waits;
    int m_stalls;
    int m_flushes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [4:0] ctl_now();
        return {hc.freeze_if, hc.freeze_id, hc.flush_if, hc.flush_id, hc.freeze_all};
    endfunction

    task automatic idle();
        hc.id_valid = 0; hc.id_src1 = 0; hc.id_src1_used = 0;
        hc.id_src2 = 0; hc.id_two_src = 0;
        hc.exe_dest = 0; hc.exe_wb_en = 0; hc.exe_mem_read = 0;
        hc.mem_dest = 0; hc.mem_wb_en = 0;
        hc.mem_access = 0; hc.mem_ready = 0; hc.branch_taken = 0;
    endtask

    task automatic set_hazard(input bit load);
        hc.id_valid = 1; hc.id_src1 = 4'd3; hc.id_src1_used = 1;
        hc.exe_dest = 4'd3; hc.exe_wb_en = 1; hc.exe_mem_read = load;
    endtask

    // Which registers are still in flight and not obtainable by the ID stage.
    function automatic bit model_hazard();
        int writers[$];
        bit hit = 0;
        if (hc.exe_wb_en && (!FWD || hc.exe_mem_read)) writers.push_back(int'(hc.exe_dest));
        if (!FWD && hc.mem_wb_en) writers.push_back(int'(hc.mem_dest));
        foreach (writers[i]) begin
            if (hc.id_src1_used && int'(hc.id_src1) == writers[i]) hit = 1;
            if (hc.id_two_src   && int'(hc.id_src2) == writers[i]) hit = 1;
        end
        return hc.id_valid && hit;
    endfunction

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic step(input string tag);
        logic [4:0] exp_ctl;
        bit wait_now;
        wait_now = 0;
        @(negedge clk);
        if (m_halted) begin
            exp_ctl = 5'b11001;
        end else begin
            wait_now = m_waiting ? !hc.mem_ready : (hc.mem_access && !hc.mem_ready);
            if (wait_now)              exp_ctl = 5'b11001;
            else if (hc.branch_taken)  exp_ctl = 5'b00110;
            else if (model_hazard())   exp_ctl = 5'b11010;
            else                       exp_ctl = 5'b00000;
        end
        chk({tag, "_ctl"},   32'(ctl_now()),        32'(exp_ctl));
        chk({tag, "_tmo"},   32'(hc.mem_timeout),   32'(m_timeout));
        chk({tag, "_stall"}, 32'(hc.stall_count),   32'(sat(m_stalls)));
        chk({tag, "_flush"}, 32'(hc.flush_count),   32'(sat(m_flushes)));
        if (!m_halted) begin
            if (exp_ctl[3]) m_stalls++;
            if (exp_ctl[2]) m_flushes++;
            if (wait_now) begin
                m_waits   = m_waiting ? m_waits + 1 : 1;
                m_waiting = 1;
                if (m_waits >= MAXW) begin
                    m_halted  = 1;
                    m_timeout = 1;
                end
            end else begin
                m_waiting = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        #1;
        chk("rst_ctl",   32'(ctl_now()),      32'd0);
        chk("rst_tmo",   32'(hc.mem_timeout), 32'd0);
        chk("rst_stall", 32'(hc.stall_count), 32'd0);
        chk("rst_flush", 32'(hc.flush_count), 32'd0);
        m_halted = 0; m_waiting = 0; m_timeout = 0;
        m_waits = 0; m_stalls = 0; m_flushes = 0;
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        rst = 0;
        idle();
        do_reset();
        step("idle");

        // Non-load writeback match in EX, then a load-use match.
        set_hazard(1'b0);
        step("haz_alu");
        idle();
        chk("tp_haz_alu_stall", 32'(hc.stall_count), FWD ? 32'd0 : 32'd1);
        set_hazard(1'b1);
        step("haz_load");
        idle();
        chk("tp_haz_load_stall", 32'(hc.stall_count), FWD ? 32'd1 : 32'd2);
        do_reset();

        // Branch wins over a hazard.
        set_hazard(1'b1);
        hc.branch_taken = 1;
        step("br_haz");
        idle();
        chk("tp_br_flush", 32'(hc.flush_count), 32'd1);
        chk("tp_br_stall", 32'(hc.stall_count), 32'd0);
        do_reset();

        // Branch held across a 4-cycle memory wait.
        hc.mem_access = 1; hc.mem_ready = 0; hc.branch_taken = 1;
        for (int i = 0; i < 4; i++) step("memw");
        hc.mem_ready = 1;
        step("memw_rel");
        idle();
        step("memw_after");
        chk("tp_memw_stall", 32'(hc.stall_count), 32'd4);
        chk("tp_memw_flush", 32'(hc.flush_count), 32'd1);
        do_reset();

        // Watchdog: 15 wait cycles trip it; HALT persists until reset.
        hc.mem_access = 1; hc.mem_ready = 0;
        for (int i = 0; i < MAXW - 1; i++) step("tmo_wait");
        chk("tp_tmo_before", 32'(hc.mem_timeout), 32'd0);
        step("tmo_last");
        chk("tp_tmo_set", 32'(hc.mem_timeout), 32'd1);
        hc.mem_ready = 1; hc.branch_taken = 1;
        for (int i = 0; i < 3; i++) step("halt");
        hc.mem_ready = 0; hc.branch_taken = 0;
        rst = 0;
        #1;
        chk("tp_tmo_rst_clr",    32'(hc.mem_timeout), 32'd0);
        chk("tp_tmo_rst_freeze", 32'(hc.freeze_all),  32'd1);
        do_reset();

        // Stall counter saturation.
        set_hazard(1'b1);
        for (int i = 0; i < (1 << CNT_W) + 5; i++) step("sat");
        idle();
        chk("tp_sat_stall", 32'(hc.stall_count), 32'(SAT));
        do_reset();

        // Randomized traffic with small register indices to provoke matches.
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            hc.id_valid     = ($urandom_range(0, 3) != 0);
            hc.id_src1      = 4'($urandom_range(0, 3));
            hc.id_src1_used = ($urandom_range(0, 3) != 0);
            hc.id_src2      = 4'($urandom_range(0, 3));
            hc.id_two_src   = $urandom_range(0, 1) == 1;
            hc.exe_dest     = 4'($urandom_range(0, 3));
            hc.exe_wb_en    = $urandom_range(0, 1) == 1;
            hc.exe_mem_read = $urandom_range(0, 1) == 1;
            hc.mem_dest     = 4'($urandom_range(0, 3));
            hc.mem_wb_en    = $urandom_range(0, 1) == 1;
            hc.mem_access   = ($urandom_range(0, 9) < 3);
            hc.mem_ready    = ($urandom_range(0, 9) < 7);
            hc.branch_taken = ($urandom_range(0, 19) < 3);
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
